// File: rtl/dmem_pkg.sv
// Shared types and helpers for the line-burst backing data memory.
package dmem_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRdWait  = 3'd1,
    StRdBurst = 3'd2,
    StWrBurst = 3'd3,
    StWrWait  = 3'd4,
    StDone    = 3'd5
  } dmem_state_e;

  function automatic int unsigned burst_cnt_width(input int unsigned block_words);
    return $clog2(block_words);
  endfunction

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port word RAM with synchronous registered read; filled with RAM[i] = i at time zero.
module dmem_sp_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 14
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [1 << DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] r_rdata;

  initial begin
    for (int i = 0; i < (1 << DEPTH_LOG2); i++) begin
      r_mem[i] = DATA_WIDTH'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_burst_ctrl.sv
// Latency-modelled backing memory serving whole cache lines as read/write bursts.
module dmem_burst_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 14,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned RD_LATENCY  = 20,
  parameter int unsigned WR_LATENCY  = 4,
  parameter int unsigned CWF         = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  done
);

  localparam int unsigned KW    = burst_cnt_width(BLOCK_WORDS);
  localparam int unsigned LW    = DEPTH_LOG2 - KW;
  localparam int unsigned WaitW = $clog2(RD_LATENCY + WR_LATENCY + 2);

  localparam logic [KW-1:0]    BeatLast   = KW'(BLOCK_WORDS - 1);
  localparam logic [WaitW-1:0] RdWaitLast = (RD_LATENCY == 0) ? '0 : WaitW'(RD_LATENCY - 1);
  localparam logic [WaitW-1:0] WrWaitLast = (WR_LATENCY == 0) ? '0 : WaitW'(WR_LATENCY - 1);

  dmem_state_e            r_state, w_state_d;
  logic [LW-1:0]          r_base, w_base_d;
  logic [KW-1:0]          r_off, w_off_d;
  logic [KW-1:0]          r_beat, w_beat_d;
  logic [WaitW-1:0]       r_wait, w_wait_d;

  logic [DEPTH_LOG2-1:0]  w_idx;
  logic [KW-1:0]          w_fetch_k;
  logic [KW-1:0]          w_rd_low;
  logic                   w_we;
  logic [DEPTH_LOG2-1:0]  w_ram_addr;
  logic [DATA_WIDTH-1:0]  w_ram_rdata;

  assign w_idx = req_addr[DEPTH_LOG2-1:0];

  if (ADDR_WIDTH > DEPTH_LOG2) begin : g_upper
    logic w_unused_addr;
    assign w_unused_addr = ^req_addr[ADDR_WIDTH-1:DEPTH_LOG2];
  end

  always_comb begin
    w_state_d = r_state;
    w_base_d  = r_base;
    w_off_d   = r_off;
    w_beat_d  = r_beat;
    w_wait_d  = r_wait;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_base_d = w_idx[DEPTH_LOG2-1:KW];
          w_off_d  = w_idx[KW-1:0];
          w_beat_d = '0;
          w_wait_d = '0;
          if (req_write)            w_state_d = StWrBurst;
          else if (RD_LATENCY == 0) w_state_d = StRdBurst;
          else                      w_state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (r_wait == RdWaitLast) begin
          w_wait_d  = '0;
          w_state_d = StRdBurst;
        end else begin
          w_wait_d = r_wait + WaitW'(1);
        end
      end
      StRdBurst: begin
        if (r_beat == BeatLast) begin
          w_beat_d  = '0;
          w_state_d = StDone;
        end else begin
          w_beat_d = r_beat + KW'(1);
        end
      end
      StWrBurst: begin
        if (wr_valid) begin
          if (r_beat == BeatLast) begin
            w_beat_d  = '0;
            w_state_d = (WR_LATENCY == 0) ? StDone : StWrWait;
          end else begin
            w_beat_d = r_beat + KW'(1);
          end
        end
      end
      StWrWait: begin
        if (r_wait == WrWaitLast) begin
          w_wait_d  = '0;
          w_state_d = StDone;
        end else begin
          w_wait_d = r_wait + WaitW'(1);
        end
      end
      default: begin
        w_beat_d  = '0;
        w_wait_d  = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  // The RAM read registered at this edge is the beat presented next cycle.
  assign w_fetch_k  = (r_state == StRdBurst) ? r_beat + KW'(1) : '0;
  assign w_rd_low   = (CWF != 0) ? w_off_d + w_fetch_k : w_fetch_k;
  assign w_we       = (r_state == StWrBurst) && wr_valid;
  assign w_ram_addr = w_we ? {r_base, r_beat} : {w_base_d, w_rd_low};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_base  <= '0;
      r_off   <= '0;
      r_beat  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_d;
      r_base  <= w_base_d;
      r_off   <= w_off_d;
      r_beat  <= w_beat_d;
      r_wait  <= w_wait_d;
    end
  end

  dmem_sp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_addr (w_ram_addr),
    .i_wdata(wr_data),
    .o_rdata(w_ram_rdata)
  );

  assign req_ready = (r_state == StIdle);
  assign wr_ready  = (r_state == StWrBurst);
  assign rd_valid  = (r_state == StRdBurst);
  assign rd_last   = rd_valid && (r_beat == BeatLast);
  assign rd_data   = rd_valid ? w_ram_rdata : '0;
  assign done      = (r_state == StDone);

endmodule

// File: tb/tb_dmem_burst_ctrl.sv
// Directed bench: default build (CWF=1), linear build (CWF=0) and zero-latency build.
module tb_dmem_burst_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic [2:0]  req_ready, wr_ready, rd_valid, rd_last, done;
  logic [31:0] rd_data [3];

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_w [4];

  dmem_burst_ctrl u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_write(req_write),
    .req_addr(req_addr), .req_ready(req_ready[0]), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .rd_last(rd_last[0]), .done(done[0])
  );

  dmem_burst_ctrl #(.CWF(0)) u_lin (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_write(req_write),
    .req_addr(req_addr), .req_ready(req_ready[1]), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .rd_last(rd_last[1]), .done(done[1])
  );

  dmem_burst_ctrl #(.RD_LATENCY(0), .WR_LATENCY(0)) u_zero (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_write(req_write),
    .req_addr(req_addr), .req_ready(req_ready[2]), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready[2]), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]),
    .rd_last(rd_last[2]), .done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input int i);
    check("rst_req_ready", 32'(req_ready[i]), 32'd1);
    check("rst_wr_ready", 32'(wr_ready[i]), 32'd0);
    check("rst_rd_valid", 32'(rd_valid[i]), 32'd0);
    check("rst_rd_last", 32'(rd_last[i]), 32'd0);
    check("rst_rd_data", rd_data[i], 32'd0);
    check("rst_done", 32'(done[i]), 32'd0);
  endtask

  // hold=1 keeps a write request and write beats asserted through the whole read.
  task automatic do_read(input int i, input logic [31:0] addr, input logic [31:0] e [4],
                         input int lat, input bit hold);
    @(negedge clk);
    req_addr = addr; req_write = 1'b0; req_valid[i] = 1'b1;
    check("rd_accept_ready", 32'(req_ready[i]), 32'd1);
    @(posedge clk); #1;
    if (hold) begin
      req_write = 1'b1; wr_valid = 1'b1; wr_data = 32'hdead_beef;
    end else begin
      req_valid[i] = 1'b0;
    end
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      check("rd_wait_valid", 32'(rd_valid[i]), 32'd0);
      if (hold) check("rd_hold_ready", 32'(req_ready[i]), 32'd0);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("rd_valid", 32'(rd_valid[i]), 32'd1);
      check("rd_data", rd_data[i], e[b]);
      check("rd_last", 32'(rd_last[i]), 32'(b == 3));
      if (hold) check("rd_hold_ready", 32'(req_ready[i]), 32'd0);
    end
    @(negedge clk);
    check("rd_done", 32'(done[i]), 32'd1);
    check("rd_done_valid", 32'(rd_valid[i]), 32'd0);
    check("rd_done_ready", 32'(req_ready[i]), 32'd0);
    req_valid[i] = 1'b0; req_write = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check("rd_idle_ready", 32'(req_ready[i]), 32'd1);
    check("rd_idle_done", 32'(done[i]), 32'd0);
  endtask

  task automatic do_write(input int i, input logic [31:0] addr, input logic [31:0] d [4],
                          input int gap, input int wlat);
    @(negedge clk);
    req_addr = addr; req_write = 1'b1; req_valid[i] = 1'b1;
    check("wr_accept_ready", 32'(req_ready[i]), 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0; req_write = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wr_valid = 1'b1; wr_data = d[b];
      @(negedge clk);
      check("wr_ready", 32'(wr_ready[i]), 32'd1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      if (b == 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("wr_gap_ready", 32'(wr_ready[i]), 32'd1);
          check("wr_gap_done", 32'(done[i]), 32'd0);
          @(posedge clk); #1;
        end
      end
    end
    for (int c = 0; c < wlat; c++) begin
      @(negedge clk);
      check("wr_wait_done", 32'(done[i]), 32'd0);
      check("wr_wait_ready", 32'(wr_ready[i]), 32'd0);
    end
    @(negedge clk);
    check("wr_done", 32'(done[i]), 32'd1);
    @(negedge clk);
    check("wr_idle_ready", 32'(req_ready[i]), 32'd1);
  endtask

  initial begin
    bit saw_activity;
    reset = 1'b0; req_valid = '0; req_write = 1'b0; req_addr = '0;
    wr_data = '0; wr_valid = 1'b0;
    #1;
    check_idle_outputs(0);
    check_idle_outputs(2);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Critical-word-first and linear reads of word 262.
    exp_w = '{32'd262, 32'd263, 32'd260, 32'd261};
    do_read(0, 32'd262, exp_w, 20, 1'b0);
    exp_w = '{32'd260, 32'd261, 32'd262, 32'd263};
    do_read(1, 32'd262, exp_w, 20, 1'b0);

    // Gapped write of line 0x40, read back linearly.
    exp_w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(1, 32'h41, exp_w, 2, 4);
    do_read(1, 32'h40, exp_w, 20, 1'b0);

    // Write request and write beats held during a read must be ignored.
    exp_w = '{32'd256, 32'd257, 32'd258, 32'd259};
    do_read(0, 32'd256, exp_w, 20, 1'b1);
    do_read(0, 32'd256, exp_w, 20, 1'b0);

    // Reset during RD_WAIT cycle 10.
    @(negedge clk);
    req_addr = 32'd8; req_write = 1'b0; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_idle_outputs(0);
    @(negedge clk);
    reset = 1'b1;
    saw_activity = 1'b0;
    repeat (25) begin
      @(negedge clk);
      saw_activity |= done[0] | rd_valid[0];
    end
    check("rst_rd_no_done", 32'(saw_activity), 32'd0);
    exp_w = '{32'd8, 32'd9, 32'd10, 32'd11};
    do_read(0, 32'd8, exp_w, 20, 1'b0);

    // Reset after two write beats of line 128.
    @(negedge clk);
    req_addr = 32'd128; req_write = 1'b1; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; req_write = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hB0;
    @(posedge clk); #1;
    wr_data = 32'hB1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    reset = 1'b0;
    #1 check_idle_outputs(0);
    @(negedge clk);
    reset = 1'b1;
    exp_w = '{32'hB0, 32'hB1, 32'd130, 32'd131};
    do_read(0, 32'd128, exp_w, 20, 1'b0);

    // Zero-latency build.
    exp_w = '{32'd262, 32'd263, 32'd260, 32'd261};
    do_read(2, 32'd262, exp_w, 0, 1'b0);
    exp_w = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    do_write(2, 32'h10, exp_w, 0, 0);
    exp_w = '{32'hC2, 32'hC3, 32'hC0, 32'hC1};
    do_read(2, 32'h12, exp_w, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_burst_ctrl.md
# dmem_burst_ctrl

Parametrised, latency-modelled backing data memory serving whole cache lines to the data cache controller. It accepts one line-sized request at a time through a valid/ready handshake and returns a read line as a burst of `BLOCK_WORDS` beats, optionally critical-word-first. It also accepts a write-back line as a flow-controlled burst. It replaces the fixed-width, fixed-depth, 4-word memory model beneath the data cache.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bits per word.
- `ADDR_WIDTH`, 32: request address width; word-addressed.
- `DEPTH_LOG2`, 14: RAM holds 2^`DEPTH_LOG2` words.
- `BLOCK_WORDS`, 4: words per line; power of two, ≥2.
- `RD_LATENCY`, 20: wait cycles before the first read beat; 0 is legal.
- `WR_LATENCY`, 4: wait cycles after the last write beat.
- `CWF`, 1: 1 selects critical-word-first wrap order for reads; 0 selects linear order from the line base.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces the reset state.
- `req_valid`  in  1  request present.
- `req_write`  in  1  1 = line write, 0 = line read.
- `req_addr`  in  `ADDR_WIDTH`  word address.
- `req_ready`  out  1  request accepted this cycle if `req_valid` is also high.
- `wr_data`  in  `DATA_WIDTH`  write beat data.
- `wr_valid`  in  1  write beat present.
- `wr_ready`  out  1  write beat accepted.
- `rd_data`  out  `DATA_WIDTH`  read beat data.
- `rd_valid`  out  1  read beat valid; no backpressure.
- `rd_last`  out  1  final read beat of the line.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Index = `req_addr[DEPTH_LOG2-1:0]`; upper bits are ignored. Line base = index with the low log2(`BLOCK_WORDS`) bits cleared. Offset = those low bits.
- States: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT, DONE.
- IDLE: `req_ready`=1, all other outputs 0. On `req_valid`, latch base, offset and write flag.
  - Read request → RD_WAIT, or RD_BURST if `RD_LATENCY`=0.
  - Write request → WR_BURST.
- RD_WAIT: count `RD_LATENCY` cycles, then → RD_BURST.
- RD_BURST: beat counter k = 0..`BLOCK_WORDS`-1, one beat per cycle, `rd_valid`=1.
  - CWF=1: beat word = RAM[base + ((offset+k) mod `BLOCK_WORDS`)].
  - CWF=0: beat word = RAM[base+k].
  - `rd_last`=1 on k=`BLOCK_WORDS`-1, then → DONE.
- WR_BURST: `wr_ready`=1. Each cycle with `wr_valid` writes RAM[base+k] (always linear) and increments k. Gaps in `wr_valid` stall without penalty. After the last beat → WR_WAIT, or DONE if `WR_LATENCY`=0.
- WR_WAIT: count `WR_LATENCY` cycles, then → DONE.
- DONE: `done`=1 for one cycle, counters cleared, → IDLE.
- `req_valid` outside IDLE is ignored (`req_ready`=0). `wr_valid` outside WR_BURST is ignored.
- `rd_data` is registered from a synchronous RAM read and is 0 whenever `rd_valid`=0.
- RAM initialises RAM[i]=i at time zero (simulation). Reset does not alter RAM contents.
- Reset mid-operation aborts the transaction: state → IDLE, counters 0, no `done`. Beats already written remain in RAM.

## Timing
- Reset values: `req_ready`=1, `wr_ready`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0, `done`=0.
- Read accepted at edge T:
  - Beats occupy cycles T+1+`RD_LATENCY` through T+`RD_LATENCY`+`BLOCK_WORDS`.
  - `done` in the following cycle; `req_ready` high one cycle after `done`.
- Write accepted at edge T:
  - `wr_ready` from cycle T+1.
  - With no gaps, beats occupy T+1..T+`BLOCK_WORDS`.
  - Then `WR_LATENCY` wait cycles, then `done`.
- Back-to-back requests: minimum one IDLE cycle between `done` and the next acceptance.

## Structure
- Shared package `dmem_pkg`: state enum typedef; burst counter width helper `$clog2(BLOCK_WORDS)`.
- Sub-module `dmem_sp_ram`: single-port array of `DATA_WIDTH` × 2^`DEPTH_LOG2`, with write enable, synchronous registered read, and the initial fill. Address muxing and the FSM stay in the top.

## Test plan
- Read `req_addr`=262, CWF=1, default latencies → after 20 wait cycles, beats 262, 263, 260, 261 on consecutive cycles; `rd_last` on 261; `done` next cycle.
- Same read with CWF=0 → beats 260, 261, 262, 263.
- Write `req_addr`=0x41 with data A0..A3, `wr_valid` low for 2 cycles after beat 1:
  - `wr_ready` stays high through the gap.
  - `done` 4 cycles after the last beat.
  - Read of 0x40, CWF=0 → A0..A3.
- `req_valid`=1 with a write held throughout a read burst → ignored; `req_ready`=0 until IDLE; RAM unchanged.
- Reset low in RD_WAIT cycle 10 → all outputs at reset values, no `done`; next read of 8 → 8, 9, 10, 11.
- Reset low after 2 write beats → first 2 words updated, the rest unchanged.
- `RD_LATENCY`=0, `WR_LATENCY`=0 build → first read beat the cycle after acceptance; write `done` the cycle after the last beat.
